// File: rtl/tinyalu_pkg.sv
// tinyalu_pkg
// Shared types for the tinyalu command front-end: ALU opcodes, the
// controller state encoding, the packed FIFO entry width and a helper
// that classifies opcodes the ALU understands.
package tinyalu_pkg;

    typedef enum logic [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100
    } operation_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } ctrl_state_t;

    // FIFO entry layout: {a[7:0], b[7:0], op[2:0]}
    localparam int CMD_W = 19;

    // True for every defined opcode (no_op included); codes 5-7 are illegal.
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op <= 3'd4);
    endfunction

endpackage

// File: rtl/tinyalu_cmd_fifo.sv
// tinyalu_cmd_fifo
// Synchronous command FIFO with a fall-through head (rdata always shows the
// oldest entry while not empty).
// Ports:
//   clk, reset     clock, synchronous active-high reset (flushes contents)
//   push, wdata    write request and entry; ignored when full
//   pop            remove head entry; ignored when empty
//   rdata          head entry
//   full, empty    occupancy flags
//   count          number of stored entries
module tinyalu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 19
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/tinyalu_cmd_ctrl.sv
// tinyalu_cmd_ctrl
// Command front-end for tinyalu: buffers commands, drives the ALU start/done
// handshake and returns results on a valid/ready response port. no_op and
// undefined opcodes are answered locally without starting the ALU.
// Optional macro TINYALU_CTRL_TIMEOUT_EN adds a watchdog that aborts an
// ISSUE lasting TIMEOUT_CYCLES cycles with result 0, err 1.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   cmd_valid/cmd_ready, cmd_a/b/op    command input (cmd_ready = !full)
//   alu_a/b/op, alu_start              registered ALU command
//   alu_done, alu_result               ALU completion
//   rsp_valid/rsp_ready                response handshake
//   rsp_result, rsp_op, rsp_err        registered response payload
//   busy                               FIFO non-empty or FSM not idle
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for a FIFO entry; pops and classifies the head
// ST_ISSUE | alu_start high, operands held, waiting for alu_done
// ST_RESP  | rsp_valid high, payload held until rsp_ready
module tinyalu_cmd_ctrl
    import tinyalu_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [2:0]  cmd_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_op,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [2:0]  rsp_op,
    output logic        rsp_err,
    output logic        busy
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("tinyalu_cmd_ctrl: FIFO_DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
    end

    ctrl_state_t                 state_q, state_d;
    logic [CMD_W-1:0]            head;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        pop;
    logic [7:0]                  head_a, head_b;
    logic [2:0]                  head_op;

    logic [7:0]  alu_a_d, alu_b_d;
    logic [2:0]  alu_op_d;
    logic [15:0] rsp_result_d;
    logic [2:0]  rsp_op_d;
    logic        rsp_err_d;

    tinyalu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cmd_valid),
        .wdata ({cmd_a, cmd_b, cmd_op}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign {head_a, head_b, head_op} = head;
    assign cmd_ready = !fifo_full;
    assign busy      = (fifo_count != '0) || (state_q != ST_IDLE);

`ifdef TINYALU_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            wd_expired;

    // wd_cnt counts completed ISSUE cycles, so it reads TIMEOUT_CYCLES-1
    // during the last permitted ISSUE cycle.
    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || state_q != ST_ISSUE) wd_cnt <= '0;
        else                              wd_cnt <= wd_cnt + 1'b1;
    end
`endif

    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        alu_a_d      = alu_a;
        alu_b_d      = alu_b;
        alu_op_d     = alu_op;
        rsp_result_d = rsp_result;
        rsp_op_d     = rsp_op;
        rsp_err_d    = rsp_err;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    rsp_op_d = head_op;
                    if (head_op == no_op || !is_legal_op(head_op)) begin
                        state_d      = ST_RESP;
                        rsp_result_d = 16'h0000;
                        rsp_err_d    = (head_op != no_op);
                    end else begin
                        state_d  = ST_ISSUE;
                        alu_a_d  = head_a;
                        alu_b_d  = head_b;
                        alu_op_d = head_op;
                    end
                end
            end
            ST_ISSUE: begin
                if (alu_done) begin
                    state_d      = ST_RESP;
                    rsp_result_d = alu_result;
                    rsp_err_d    = 1'b0;
                end
`ifdef TINYALU_CTRL_TIMEOUT_EN
                else if (wd_expired) begin
                    state_d      = ST_RESP;
                    rsp_result_d = 16'h0000;
                    rsp_err_d    = 1'b1;
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // alu_start and rsp_valid are registered copies of the next state so
    // both outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            alu_start  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_op     <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_a      <= alu_a_d;
            alu_b      <= alu_b_d;
            alu_op     <= alu_op_d;
            alu_start  <= (state_d == ST_ISSUE);
            rsp_valid  <= (state_d == ST_RESP);
            rsp_result <= rsp_result_d;
            rsp_op     <= rsp_op_d;
            rsp_err    <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_tinyalu_cmd_ctrl.sv
module tb_tinyalu_cmd_ctrl;
    import tinyalu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_a = '0, cmd_b = '0;
    logic [2:0]  cmd_op = '0;
    logic [7:0]  alu_a, alu_b;
    logic [2:0]  alu_op;
    logic        alu_start;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_result;
    logic [2:0]  rsp_op;
    logic        rsp_err;
    logic        busy;

    always #5 clk = ~clk;

    tinyalu_cmd_ctrl #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
        .alu_done(alu_done), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_err(rsp_err),
        .busy(busy)
    );

    // tinyalu behavioural model: single-cycle ops assert done one cycle after
    // each sampled start (so done lingers one cycle after start drops); mul
    // asserts done in the fourth cycle after start first rises.
    logic        alu_hang = 1'b0;
    logic        done_sc = 1'b0;
    logic [3:0]  mcnt = '0;
    logic [15:0] res_q = '0;

    always @(posedge clk) begin
        if (reset) begin
            done_sc <= 1'b0;
            mcnt    <= '0;
        end else begin
            done_sc <= alu_start && (alu_op == 3'd1 || alu_op == 3'd2 || alu_op == 3'd3);
            if (alu_start && alu_op == 3'd4) mcnt <= mcnt + 4'd1;
            else                             mcnt <= '0;
            case (alu_op)
                3'd1:    res_q <= 16'(alu_a) + 16'(alu_b);
                3'd2:    res_q <= {8'h00, alu_a & alu_b};
                3'd3:    res_q <= {8'h00, alu_a ^ alu_b};
                3'd4:    res_q <= 16'(alu_a) * 16'(alu_b);
                default: res_q <= 16'h0000;
            endcase
        end
    end

    assign alu_done   = !alu_hang && (done_sc || mcnt == 4'd4);
    assign alu_result = res_q;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Response entry: {op, err, result}
    function automatic logic [19:0] expect_rsp(input logic [7:0] a, input logic [7:0] b,
                                               input logic [2:0] op);
        logic [15:0] r;
        logic        e;
        r = 16'h0000;
        e = 1'b0;
        case (op)
            3'd0: ;
            3'd1: r = 16'(a) + 16'(b);
            3'd2: r = {8'h00, a & b};
            3'd3: r = {8'h00, a ^ b};
            3'd4: r = 16'(a) * 16'(b);
            default: e = 1'b1;
        endcase
        return {op, e, r};
    endfunction

    logic [19:0] sb[$];
    logic        stalled = 1'b0;
    logic [19:0] held = '0;

    always @(negedge clk) begin
        if (reset) begin
            stalled <= 1'b0;
        end else begin
            if (stalled && rsp_valid)
                chk("rsp_stable", {rsp_op, rsp_err, rsp_result}, held);
            if (rsp_valid && rsp_ready) begin
                chk("sb_has_entry", (sb.size() != 0), 1);
                if (sb.size() != 0)
                    chk("rsp", {rsp_op, rsp_err, rsp_result}, sb.pop_front());
            end
            stalled <= rsp_valid && !rsp_ready;
            held    <= {rsp_op, rsp_err, rsp_result};
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_zero"}, {alu_a, alu_b, alu_op, alu_start, rsp_valid, rsp_result,
                             rsp_op, rsp_err, busy}, 64'h0);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
    endtask

    // Drives one command into an idle, empty block with rsp_ready=1 and checks
    // cycle numbers relative to the handshake cycle (cycle 0).
    task automatic run_timed(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [2:0] op, input logic [19:0] exp,
                             input int rsp_cyc, input int st_first, input int st_last);
        int first_st = -1;
        int last_st  = -1;
        int got_rsp  = -1;
        chk({tag, "_ready"}, cmd_ready, 1);
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        sb.push_back(exp);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (alu_start) begin
                if (first_st < 0) first_st = c;
                last_st = c;
            end
            if (rsp_valid) begin
                got_rsp = c;
                break;
            end
            @(posedge clk); #1;
        end
        chk({tag, "_rsp_cycle"}, got_rsp, rsp_cyc);
        chk({tag, "_start_first"}, first_st, st_first);
        chk({tag, "_start_last"}, last_st, st_last);
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input string tag);
        for (int c = 0; c < 300 && (sb.size() != 0 || busy); c++) begin
            @(posedge clk); #1;
        end
        chk({tag, "_sb_empty"}, sb.size(), 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int n_acc;
        int waited;
        logic acc;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_init");
        reset = 1'b0;
        @(posedge clk); #1;

        rsp_ready = 1'b1;
        run_timed("add", 8'hFF, 8'h01, 3'(add_op), {3'(add_op), 1'b0, 16'h0100}, 4, 2, 3);
        run_timed("mul", 8'hFF, 8'hFF, 3'(mul_op), {3'(mul_op), 1'b0, 16'hFE01}, 7, 2, 6);
        run_timed("noop", 8'h55, 8'hAA, 3'(no_op), {3'(no_op), 1'b0, 16'h0000}, 2, -1, -1);
        run_timed("illegal", 8'h55, 8'hAA, 3'b110, {3'b110, 1'b1, 16'h0000}, 2, -1, -1);

        // Two commands with the consumer stalled for five cycles.
        rsp_ready = 1'b0;
        cmd_a = 8'hF0; cmd_b = 8'h3C; cmd_op = 3'(and_op); cmd_valid = 1'b1;
        sb.push_back(expect_rsp(8'hF0, 8'h3C, 3'(and_op)));
        @(posedge clk); #1;
        cmd_op = 3'(xor_op);
        sb.push_back(expect_rsp(8'hF0, 8'h3C, 3'(xor_op)));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        waited = 0;
        while (!rsp_valid && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("stall_rsp_seen", rsp_valid, 1);
        repeat (5) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_drain("stall");

        // Fill: five mul commands with the consumer stalled; then reset mid-mul.
        rsp_ready = 1'b0;
        n_acc = 0;
        for (int g = 0; g < 10 && n_acc < 5; g++) begin
            cmd_a = 8'(8'h10 + g); cmd_b = 8'h03; cmd_op = 3'(mul_op); cmd_valid = 1'b1;
            acc = cmd_ready;
            @(posedge clk); #1;
            if (acc) begin
                sb.push_back(expect_rsp(cmd_a, cmd_b, cmd_op));
                n_acc++;
            end
        end
        chk("fill_accepts", n_acc, 5);
        chk("fill_ready_low", cmd_ready, 0);
        chk("fill_mid_mul", alu_start, 1);
        cmd_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        sb.delete();
        check_reset_outputs("reset_mid_mul");
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_idle", {busy, alu_start, rsp_valid}, 0);

        // Random burst with a randomly stalling consumer.
        begin
            int sent = 0;
            for (int guard = 0; guard < 400 && sent < 12; guard++) begin
                rsp_ready = 1'($urandom_range(0, 1));
                cmd_a = 8'($urandom_range(0, 255));
                cmd_b = 8'($urandom_range(0, 255));
                cmd_op = 3'($urandom_range(0, 7));
                cmd_valid = 1'($urandom_range(0, 1));
                if (cmd_valid && cmd_ready) begin
                    sb.push_back(expect_rsp(cmd_a, cmd_b, cmd_op));
                    sent++;
                end
                @(posedge clk); #1;
            end
            cmd_valid = 1'b0;
            rsp_ready = 1'b1;
            chk("burst_sent", sent, 12);
            wait_drain("burst");
        end

`ifdef TINYALU_CTRL_TIMEOUT_EN
        alu_hang = 1'b1;
        run_timed("wdog", 8'h12, 8'h34, 3'(add_op), {3'(add_op), 1'b1, 16'h0000}, 18, 2, 17);
        alu_hang = 1'b0;
        @(posedge clk); #1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
